// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The HALT state and halt-idiom matcher exist only when IFETCH_HALT_DETECT_EN is defined.
package ifetch_pkg;

   localparam int ENTRY_INST_W = 32;
   localparam int ENTRY_PC_W   = 64;

   localparam logic [ENTRY_INST_W-1:0] HALT_INSN = 32'hB400001F;
   localparam logic [ENTRY_INST_W-1:0] HALT_MASK = 32'hFFFFFFFF;

`ifdef IFETCH_HALT_DETECT_EN
   typedef enum logic [1:0] {RUN, FULL, HALT} fetch_state_t;
`else
   typedef enum logic [1:0] {RUN, FULL} fetch_state_t;
`endif

   typedef struct packed {
      logic [ENTRY_INST_W-1:0] inst;
      logic [ENTRY_PC_W-1:0]   pc;
   } fifo_entry_t;

`ifdef IFETCH_HALT_DETECT_EN
   // CBZ XZR,#0 is used by software as a "stop fetching" marker.
   function automatic logic is_halt(input logic [ENTRY_INST_W-1:0] w);
      return (w & HALT_MASK) == HALT_INSN;
   endfunction
`endif

endpackage

// File: rtl/ifetch_fifo.sv
// Small prefetch FIFO for fetched {inst, pc} entries; flush empties it in one cycle.
// Head is combinational from storage, so a pop and a push into the same slot may share a cycle.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fifo_entry_t
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  entry_t                   wdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output entry_t                   head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t         mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  cnt;
   logic           do_push;
   logic           do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = cnt;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries data only; validity is tracked by cnt.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the imem address, feeds decode via a prefetch FIFO.
// Optional macro IFETCH_HALT_DETECT_EN enables stopping fetch on the CBZ XZR,#0 halt idiom.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int              N        = 32,
   parameter int              AW       = 6,
   parameter int              PC_W     = 64,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [AW-1:0]    imem_addr,
   input  logic [N-1:0]     imem_q,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             inst_valid,
   output logic [N-1:0]     inst,
   output logic [PC_W-1:0]  inst_pc,
   input  logic             inst_ready,
   output logic [PC_W-1:0]  fetch_pc,
   output logic             halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t   state;
   fetch_state_t   state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_nxt;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           halt_st;
   fifo_entry_t    head;
   fifo_entry_t    wentry;

   assign imem_addr  = fetch_pc[AW+1:2];
   assign inst_valid = !empty;
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready;
   assign push       = !redirect_valid && !halt_st && (!full || pop);

   always_comb begin
      wentry      = '0;
      wentry.inst = imem_q;
      wentry.pc   = fetch_pc;
   end

`ifdef IFETCH_HALT_DETECT_EN
   logic halt_hit;
   assign halt_hit = push && is_halt(imem_q);
   assign halt_st  = (state == HALT);
`else
   assign halt_st  = 1'b0;
`endif
   assign halted = halt_st;

   ifetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fifo_entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wentry),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Redirect wins over everything, including HALT; HALT freezes the PC.
   always_comb begin
      state_nxt = state;
      pc_nxt    = fetch_pc;
      if (redirect_valid) begin
         state_nxt = RUN;
         pc_nxt    = redirect_pc & ~PC_W'(3);
      end else if (!halt_st) begin
         if (push) pc_nxt = fetch_pc + PC_W'(4);
         state_nxt = (count_nxt == CW'(DEPTH)) ? FULL : RUN;
`ifdef IFETCH_HALT_DETECT_EN
         if (halt_hit) state_nxt = HALT;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= pc_nxt;
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus random ready/redirect/reset traffic,
// checked every cycle against a queue-based model of the fetch stream.
module tb_ifetch_ctrl;

   localparam int          N        = 32;
   localparam int          AW       = 6;
   localparam int          PC_W     = 64;
   localparam int          DEPTH    = 2;
   localparam logic [63:0] RESET_PC = '0;
`ifdef IFETCH_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   imem_addr;
   logic [N-1:0]    imem_q;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            inst_valid;
   logic [N-1:0]    inst;
   logic [PC_W-1:0] inst_pc;
   logic            inst_ready;
   logic [PC_W-1:0] fetch_pc;
   logic            halted;

   logic [31:0] rom [64];
   assign imem_q = rom[imem_addr];

   always #5 clk = ~clk;

   ifetch_ctrl #(
      .N(N), .AW(AW), .PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fetch_pc       (fetch_pc),
      .halted         (halted)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_pc;
   bit          m_halt;
   int          total = 0;
   int          bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: the decode-side stream is a queue of {word, pc} pairs.
   task automatic model_edge();
      bit   popped;
      bit   pushed;
      ent_t e;
      if (redirect_valid) begin
         mq.delete();
         m_pc   = redirect_pc & ~64'h3;
         m_halt = 1'b0;
      end else begin
         popped = (mq.size() > 0) && inst_ready;
         pushed = !m_halt && ((mq.size() < DEPTH) || popped);
         e.inst = rom[m_pc[AW+1:2]];
         e.pc   = m_pc;
         if (popped) void'(mq.pop_front());
         if (pushed) begin
            mq.push_back(e);
            m_pc = m_pc + 64'd4;
            if (HALT_EN && e.inst == 32'hB400001F) m_halt = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_val("inst_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check_val("inst", inst, mq[0].inst);
         check_val("inst_pc", inst_pc, mq[0].pc);
      end
      check_val("fetch_pc", fetch_pc, m_pc);
      check_val("imem_addr", imem_addr, m_pc[AW+1:2]);
      check_val("halted", halted, m_halt);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      redirect_valid = 1'b0;
      reset = 1'b0;
      mq.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
      #1;
      check_val("rst_valid", inst_valid, 1'b0);
      compare_all();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   logic [63:0] last_pc;

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hF8000000 | (i << 15) | (i + 1);
      rom[29] = 32'hB4FFFF82;
      rom[46] = 32'hB400001F;
      reset          = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #3;

      // Straight-line fetch with decode always ready
      inst_ready = 1'b1;
      do_reset();
      step();
      check_val("t1_first_pc", inst_pc, 64'h0);
      check_val("t1_first_inst", inst, 64'hF8000001);
      for (int i = 0; i < 6; i++) step();

      // Decode stall: buffer fills to two entries, then resumes
      do_reset();
      step();
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_val("t2_fetch_pc", fetch_pc, 64'h8);
      check_val("t2_head", inst, 64'hF8000001);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Redirect while full, same cycle as a pop
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h74;
      step();
      check_val("t3_flush", inst_valid, 1'b0);
      redirect_valid = 1'b0;
      step();
      check_val("t3_pc", inst_pc, 64'h74);
      check_val("t3_inst", inst, 64'hB4FFFF82);

      // Unaligned redirect past the ROM end aliases word 0
      redirect_valid = 1'b1;
      redirect_pc    = 64'h103;
      step();
      check_val("t4_fetch_pc", fetch_pc, 64'h100);
      check_val("t4_addr", imem_addr, 64'h0);
      redirect_valid = 1'b0;
      step();
      check_val("t4_inst", inst, 64'hF8000001);
      check_val("t4_pc", inst_pc, 64'h100);

      // Halt idiom at 0xB8
      redirect_valid = 1'b1;
      redirect_pc    = 64'hA8;
      step();
      redirect_valid = 1'b0;
      last_pc = '0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (inst_valid) last_pc = inst_pc;
      end
      if (HALT_EN) begin
         check_val("t5_halted", halted, 1'b1);
         check_val("t5_last_pc", last_pc, 64'hB8);
         check_val("t5_fetch_pc", fetch_pc, 64'hBC);
      end else begin
         check_val("t5_halted", halted, 1'b0);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      step();
      check_val("t5_clear", halted, 1'b0);
      redirect_valid = 1'b0;

      // Reset with two entries buffered
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_val("t6_buffered", mq.size(), 64'd2);
      do_reset();
      inst_ready = 1'b1;
      step();
      check_val("t6_restart", inst_pc, RESET_PC);
      for (int i = 0; i < 3; i++) step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 64'($urandom_range(0, 'h12F));
         if ($urandom_range(0, 199) == 0) do_reset();
         else step();
      end
      redirect_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
